// File: rtl/right_pad_ai_pkg.sv
// Shared constants and types for the right-paddle computer opponent.
// Screen geometry, game-state encoding, AI FSM states and tracking target helper.
package right_pad_ai_pkg;

  localparam int HOR_PIXELS    = 1024;
  localparam int VER_PIXELS    = 768;
  localparam logic [1:0] STATE_PLAY = 2'd1;

  localparam int PAD_HEIGHT    = 145;
  localparam int BALL_SIZE     = 15;
  localparam int PAD_SPEED     = 2;
  localparam int REACT_DELAY   = 8;
  localparam int DEAD_ZONE     = 4;
  localparam int X_TRACK_START = 512;
  localparam int JUMP_LIMIT    = 64;

  localparam int Y_MAX  = VER_PIXELS - PAD_HEIGHT;
  localparam int CENTER = Y_MAX / 2;
  localparam int CNT_W  = $clog2(REACT_DELAY);

  localparam logic signed [11:0] Y_MAX_S     = 12'(Y_MAX);
  localparam logic signed [11:0] CENTER_S    = 12'(CENTER);
  localparam logic signed [11:0] SPEED_S     = 12'(PAD_SPEED);
  localparam logic signed [11:0] DEAD_S      = 12'(DEAD_ZONE);
  localparam logic signed [11:0] JUMP_S      = 12'(JUMP_LIMIT);
  localparam logic signed [11:0] TRACK_OFS_S = 12'(BALL_SIZE / 2 - PAD_HEIGHT / 2);

  typedef enum logic [1:0] {
    AI_IDLE   = 2'd0,
    AI_RETURN = 2'd1,
    AI_REACT  = 2'd2,
    AI_TRACK  = 2'd3
  } ai_state_t;

  // Pad top that centres the paddle on the ball; may be out of range before clamping.
  function automatic logic signed [11:0] track_target(input logic [9:0] y);
    return $signed({2'b00, y}) + TRACK_OFS_S;
  endfunction

endpackage

// File: rtl/right_pad_ai_pad_stepper.sv
// Combinational paddle mover: clamps the target to the playfield, ignores small
// errors and limits each step to PAD_SPEED pixels.
module right_pad_ai_pad_stepper
  import right_pad_ai_pkg::*;
(
  input  logic signed [11:0] target,
  input  logic        [9:0]  pos,
  output logic        [9:0]  pos_nxt
);

  logic signed [11:0] tgt_clamped;
  logic signed [11:0] pos_s;
  logic signed [11:0] err;
  logic signed [11:0] abs_err;
  logic signed [11:0] step;

  always_comb begin
    tgt_clamped = target;
    if (target < 12'sd0) begin
      tgt_clamped = 12'sd0;
    end else if (target > Y_MAX_S) begin
      tgt_clamped = Y_MAX_S;
    end

    pos_s   = $signed({2'b00, pos});
    err     = tgt_clamped - pos_s;
    abs_err = (err < 12'sd0) ? -err : err;
    step    = (abs_err < SPEED_S) ? abs_err : SPEED_S;

    // Target is clamped and step never exceeds |err|, so the result stays in range.
    pos_nxt = pos;
    if (abs_err > DEAD_S) begin
      pos_nxt = 10'((err < 12'sd0) ? (pos_s - step) : (pos_s + step));
    end
  end

endmodule

// File: rtl/right_pad_ai.sv
// Right-paddle computer opponent: watches ball motion, waits REACT_DELAY ticks after
// an approaching ball is seen, then slews the paddle toward the ball.
module right_pad_ai
  import right_pad_ai_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic [1:0]  state,
  input  logic [10:0] x_ball,
  input  logic [9:0]  y_ball,
  output logic [9:0]  y_pad_right,
  output logic [1:0]  ai_state
);

  ai_state_t          ai_state_q, ai_state_d;
  logic [CNT_W-1:0]   react_cnt_q, react_cnt_d;
  logic               hist_valid_q, hist_valid_d;
  logic [10:0]        x_prev_q, x_prev_d;
  logic [9:0]         pad_q, pad_d;

  logic               play;
  logic signed [11:0] x_diff;
  logic               dir_right;
  logic               dir_left;
  logic               respawn;
  logic signed [11:0] target;
  logic [9:0]         pos_nxt;

  always_comb begin
    play      = (state == STATE_PLAY);
    x_diff    = $signed({1'b0, x_ball}) - $signed({1'b0, x_prev_q});
    dir_right = hist_valid_q && (x_ball > x_prev_q);
    dir_left  = hist_valid_q && (x_ball < x_prev_q);
    respawn   = hist_valid_q && ((x_diff > JUMP_S) || (x_diff < -JUMP_S));
  end

  always_comb begin
    ai_state_d   = ai_state_q;
    react_cnt_d  = react_cnt_q;
    hist_valid_d = hist_valid_q;
    x_prev_d     = x_prev_q;

    if (!play) begin
      ai_state_d   = AI_IDLE;
      hist_valid_d = 1'b0;
    end else if (ai_state_q == AI_IDLE) begin
      // Leaving IDLE does not wait for a tick; history restarts from scratch.
      ai_state_d   = AI_RETURN;
      hist_valid_d = 1'b0;
      if (timing_tick) begin
        x_prev_d = x_ball;
      end
    end else if (timing_tick) begin
      x_prev_d     = x_ball;
      hist_valid_d = 1'b1;
      if (respawn) begin
        ai_state_d   = AI_RETURN;
        hist_valid_d = 1'b0;
      end else begin
        unique case (ai_state_q)
          AI_RETURN: begin
            if (dir_right && (x_ball >= 11'(X_TRACK_START))) begin
              ai_state_d  = AI_REACT;
              react_cnt_d = '0;
            end
          end
          AI_REACT: begin
            react_cnt_d = CNT_W'(react_cnt_q + 1'b1);
            if (dir_left) begin
              ai_state_d = AI_RETURN;
            end else if (react_cnt_q == CNT_W'(REACT_DELAY - 1)) begin
              ai_state_d = AI_TRACK;
            end
          end
          AI_TRACK: begin
            if (dir_left) begin
              ai_state_d = AI_RETURN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The pad follows the target rule of the state being entered, not the one left.
  always_comb begin
    target = $signed({2'b00, pad_q});
    case (ai_state_d)
      AI_RETURN: target = CENTER_S;
      AI_TRACK:  target = track_target(y_ball);
      default:   ;
    endcase
  end

  right_pad_ai_pad_stepper u_stepper (
    .target  (target),
    .pos     (pad_q),
    .pos_nxt (pos_nxt)
  );

  always_comb begin
    pad_d = pad_q;
    if (!play || (ai_state_q == AI_IDLE)) begin
      pad_d = 10'(CENTER);
    end else if (timing_tick) begin
      pad_d = pos_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ai_state_q   <= AI_IDLE;
      react_cnt_q  <= '0;
      hist_valid_q <= 1'b0;
      x_prev_q     <= '0;
      pad_q        <= 10'(CENTER);
    end else begin
      ai_state_q   <= ai_state_d;
      react_cnt_q  <= react_cnt_d;
      hist_valid_q <= hist_valid_d;
      x_prev_q     <= x_prev_d;
      pad_q        <= pad_d;
    end
  end

  assign y_pad_right = pad_q;
  assign ai_state    = ai_state_q;

endmodule

// File: tb/tb_right_pad_ai.sv
// Bench for right_pad_ai: directed scenarios with literal expectations, then random play,
// all checked every cycle against an integer reference model of the paddle AI.
module tb_right_pad_ai;

  logic        clk = 1'b0;
  logic        rst;
  logic        timing_tick;
  logic [1:0]  state;
  logic [10:0] x_ball;
  logic [9:0]  y_ball;
  logic [9:0]  y_pad_right;
  logic [1:0]  ai_state;

  int total = 0;
  int bad   = 0;

  // Reference model state: 0 idle, 1 return, 2 react, 3 track.
  int m_pad = 311;
  int m_st  = 0;
  int m_cnt = 0;
  int m_hv  = 0;
  int m_xp  = 0;

  always #5 clk = ~clk;

  right_pad_ai dut (
    .clk         (clk),
    .rst         (rst),
    .timing_tick (timing_tick),
    .state       (state),
    .x_ball      (x_ball),
    .y_ball      (y_ball),
    .y_pad_right (y_pad_right),
    .ai_state    (ai_state)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_tick(input int xb, input int yb);
    int tgt;
    int e;
    int right;
    int left;
    right = (m_hv != 0) && (xb > m_xp);
    left  = (m_hv != 0) && (xb < m_xp);
    if ((m_hv != 0) && (iabs(xb - m_xp) > 64)) begin
      m_st = 1;
      m_hv = 0;
    end else begin
      m_hv = 1;
      if (m_st == 1 && right && xb >= 512) begin
        m_st  = 2;
        m_cnt = 0;
      end else if (m_st == 2) begin
        if (left) m_st = 1;
        else if (m_cnt == 7) m_st = 3;
        m_cnt++;
      end else if (m_st == 3 && left) begin
        m_st = 1;
      end
    end
    m_xp = xb;
    if (m_st == 1) tgt = 311;
    else if (m_st == 3) tgt = yb + 7 - 72;
    else tgt = m_pad;
    if (tgt < 0) tgt = 0;
    if (tgt > 623) tgt = 623;
    e = tgt - m_pad;
    if (iabs(e) > 4) m_pad += (e > 0) ? 2 : -2;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pad = 311; m_st = 0; m_cnt = 0; m_hv = 0; m_xp = 0;
    end else if (state != 2'd1) begin
      m_st = 0; m_pad = 311; m_hv = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_pad = 311; m_hv = 0;
      if (timing_tick) m_xp = int'(x_ball);
    end else if (timing_tick) begin
      model_tick(int'(x_ball), int'(y_ball));
    end
  end

  always @(negedge clk) begin
    chk("pad_vs_model", int'(y_pad_right), m_pad);
    chk("state_vs_model", int'(ai_state), m_st);
    if (y_pad_right > 10'd623) chk("pad_range", int'(y_pad_right), 623);
  end

  // One clock with the given inputs; returns shortly after the active edge.
  task automatic cyc(input bit tk, input int xb, input int yb);
    @(negedge clk);
    #1;
    timing_tick = tk;
    x_ball      = 11'(xb);
    y_ball      = 10'(yb);
    @(posedge clk);
    #1;
    timing_tick = 1'b0;
  endtask

  initial begin
    int xi;
    int yi;
    rst = 1'b1; state = 2'd0; timing_tick = 1'b0; x_ball = '0; y_ball = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pad", int'(y_pad_right), 311);
    chk("reset_state", int'(ai_state), 0);

    // Scenario 1: play without ticks leaves IDLE after one clock.
    rst = 1'b0; state = 2'd1;
    #1;
    chk("idle_before_clk", int'(ai_state), 0);
    cyc(0, 0, 0);
    chk("return_after_clk", int'(ai_state), 1);
    chk("return_pad", int'(y_pad_right), 311);

    // Scenario 2: approaching ball, reaction delay, then tracking to y=100.
    cyc(1, 600, 100);
    chk("first_tick_return", int'(ai_state), 1);
    cyc(1, 602, 100);
    chk("react_entered", int'(ai_state), 2);
    for (int i = 0; i < 7; i++) cyc(1, 604 + 2 * i, 100);
    chk("react_still", int'(ai_state), 2);
    chk("react_pad_hold", int'(y_pad_right), 311);
    cyc(1, 620, 100);
    chk("track_entered", int'(ai_state), 3);
    chk("track_first_step", int'(y_pad_right), 309);
    for (int i = 0; i < 150; i++) cyc(1, 620, 100);
    chk("track_settle", int'(y_pad_right), 39);

    // Scenario 3: target clamps at both playfield edges.
    for (int i = 0; i < 300; i++) cyc(1, 620, 760);
    chk("clamp_high", int'(y_pad_right), 619);
    for (int i = 0; i < 320; i++) cyc(1, 620, 0);
    chk("clamp_low", int'(y_pad_right), 3);

    // Scenario 4: reversal while reacting returns to centre without tracking.
    cyc(1, 618, 0);
    chk("reverse_return", int'(ai_state), 1);
    chk("reverse_step", int'(y_pad_right), 5);
    for (int i = 0; i < 151; i++) cyc(1, 618, 0);
    chk("back_to_center", int'(y_pad_right), 307);
    cyc(1, 620, 0);
    chk("react_again", int'(ai_state), 2);
    for (int i = 0; i < 5; i++) cyc(1, 622 + 2 * i, 0);
    cyc(1, 628, 0);
    chk("react_abort", int'(ai_state), 1);
    chk("react_abort_pad", int'(y_pad_right), 307);
    for (int i = 0; i < 10; i++) cyc(1, 628, 0);
    chk("no_track_after_abort", int'(ai_state), 1);

    // Scenario 5: respawn jump clears history.
    cyc(1, 668, 0);
    for (int i = 0; i < 8; i++) cyc(1, 708 + 40 * i, 0);
    chk("track_far", int'(ai_state), 3);
    cyc(1, 524, 0);
    chk("respawn_return", int'(ai_state), 1);
    cyc(1, 526, 0);
    chk("no_false_right", int'(ai_state), 1);
    cyc(1, 528, 0);
    chk("react_after_respawn", int'(ai_state), 2);

    // Scenario 6: leaving play and async reset mid-move.
    for (int i = 0; i < 8; i++) cyc(1, 530 + 2 * i, 400);
    for (int i = 0; i < 3; i++) cyc(1, 544, 400);
    chk("track_mid_move", int'(y_pad_right), 315);
    state = 2'd2;
    cyc(0, 544, 400);
    chk("nonplay_idle", int'(ai_state), 0);
    chk("nonplay_center", int'(y_pad_right), 311);
    state = 2'd1;
    cyc(0, 544, 100);
    cyc(1, 546, 100);
    cyc(1, 548, 100);
    for (int i = 0; i < 8; i++) cyc(1, 550 + 2 * i, 100);
    for (int i = 0; i < 4; i++) cyc(1, 564, 100);
    chk("track_before_rst", int'(y_pad_right), 301);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pad", int'(y_pad_right), 311);
    chk("async_rst_state", int'(ai_state), 0);
    #1 rst = 1'b0;

    // Random play checked by the per-cycle model comparison.
    xi = 600;
    yi = 300;
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(negedge clk);
      #1;
      r = $urandom_range(0, 99);
      if (r < 3) xi = $urandom_range(0, 1279);
      else if (r < 60) xi += $urandom_range(0, 5);
      else if (r < 88) xi -= $urandom_range(1, 5);
      if (xi < 0) xi = 0;
      if (xi > 1279) xi = 1279;
      if ($urandom_range(0, 49) == 0) yi = $urandom_range(0, 1023);
      if (state != 2'd1) begin
        if ($urandom_range(0, 3) == 0) state = 2'd1;
      end else if ($urandom_range(0, 299) == 0) begin
        state = 2'($urandom_range(0, 3));
      end
      timing_tick = ($urandom_range(0, 2) == 0);
      x_ball = 11'(xi);
      y_ball = 10'(yi);
      if ($urandom_range(0, 699) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
